// File: rtl/sub_div_unit_if.sv
// ---------------------------------------------------------------------------
// sub_div_unit_if
// Operand/result bundle for sub_div_unit.
//   Operand side : valid_i, ready_o, y_i (ACC_W), b_i (ACC_W), a_i (WIDTH)
//   Result side  : valid_o, ready_i, x_sat_o (WIDTH), q_full_o (D),
//                  rem_o (WIDTH), sat_o, dz_o
// slave  : the divider itself.
// master : the client that supplies operands and consumes results.
// ---------------------------------------------------------------------------
interface sub_div_unit_if #(
   parameter int WIDTH = 16,
   parameter int MAXN  = 16
);
   localparam int ACC_W = 2*WIDTH + $clog2(MAXN);
   localparam int D     = ACC_W + 1;

   logic                    valid_i;
   logic                    ready_o;
   logic signed [ACC_W-1:0] y_i;
   logic signed [ACC_W-1:0] b_i;
   logic signed [WIDTH-1:0] a_i;
   logic                    valid_o;
   logic                    ready_i;
   logic signed [WIDTH-1:0] x_sat_o;
   logic signed [D-1:0]     q_full_o;
   logic signed [WIDTH-1:0] rem_o;
   logic                    sat_o;
   logic                    dz_o;

   modport slave (
      input  valid_i, y_i, b_i, a_i, ready_i,
      output ready_o, valid_o, x_sat_o, q_full_o, rem_o, sat_o, dz_o
   );

   modport master (
      output valid_i, y_i, b_i, a_i, ready_i,
      input  ready_o, valid_o, x_sat_o, q_full_o, rem_o, sat_o, dz_o
   );
endinterface

// File: rtl/sub_div_unit.sv
// ---------------------------------------------------------------------------
// sub_div_unit
// Recovers x = (y - b) / a with a multi-cycle signed restoring divider.
//   clk_i  : clock, rising edge
//   rst_ni : synchronous active-low reset
//   bus    : sub_div_unit_if.slave
//            operands y_i, b_i (ACC_W), a_i (WIDTH) with valid_i/ready_o;
//            results x_sat_o, q_full_o, rem_o, sat_o, dz_o with
//            valid_o/ready_i.
// A nonzero divisor takes D CALC cycles plus one FIX cycle; a zero divisor
// goes straight to DONE with saturated outputs.
// ---------------------------------------------------------------------------
module sub_div_unit #(
   parameter int WIDTH = 16,
   parameter int MAXN  = 16
) (
   input  logic clk_i,
   input  logic rst_ni,
   sub_div_unit_if.slave bus
);
   localparam int ACC_W = 2*WIDTH + $clog2(MAXN);
   localparam int D     = ACC_W + 1;
   localparam int CNT_W = $clog2(D);

   localparam logic signed [WIDTH-1:0] XMAX = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic signed [WIDTH-1:0] XMIN = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

   state_t r_state;
   state_t w_state_nxt;

   logic [CNT_W-1:0] r_cnt;
   // Holds |n| at accept; quotient bits shift in from the bottom as the
   // dividend bits shift out of the top, so it ends up holding |q|.
   logic [D-1:0]     r_num;
   logic [WIDTH-1:0] r_den;
   logic [WIDTH-1:0] r_rem;
   logic             r_neg_n;
   logic             r_neg_a;

   logic signed [WIDTH-1:0] r_x_sat;
   logic signed [D-1:0]     r_q_full;
   logic signed [WIDTH-1:0] r_rem_out;
   logic                    r_sat;
   logic                    r_dz;

   logic signed [D-1:0]     w_n;
   logic [D-1:0]            w_n_mag;
   logic [WIDTH-1:0]        w_a_mag;
   logic                    w_a_zero;
   logic [WIDTH:0]          w_trial;
   logic                    w_ge;
   logic [WIDTH-1:0]        w_diff;
   logic signed [D-1:0]     w_q_fix;
   logic signed [WIDTH-1:0] w_rem_fix;
   logic [WIDTH:0]          w_sat_res;

   // Returns {clipped, value}: clipped when the bits above the WIDTH-bit
   // signed range are not a pure sign extension.
   function automatic logic [WIDTH:0] f_sat(input logic signed [D-1:0] q);
      logic clip;
      clip = !((&q[D-1:WIDTH-1]) || !(|q[D-1:WIDTH-1]));
      if (clip)
         f_sat = {1'b1, (q[D-1] ? XMIN : XMAX)};
      else
         f_sat = {1'b0, q[WIDTH-1:0]};
   endfunction

   // Exact D-bit dividend: both operands sign-extended by one bit.
   assign w_n      = {bus.y_i[ACC_W-1], bus.y_i} - {bus.b_i[ACC_W-1], bus.b_i};
   assign w_n_mag  = w_n[D-1] ? -w_n : w_n;
   // Unsigned WIDTH-bit magnitude, so -2^(WIDTH-1) maps to 2^(WIDTH-1).
   assign w_a_mag  = bus.a_i[WIDTH-1] ? -bus.a_i : bus.a_i;
   assign w_a_zero = (bus.a_i == '0);

   assign w_trial  = {r_rem, r_num[D-1]};
   assign w_ge     = (w_trial >= {1'b0, r_den});
   // Only used when w_ge, so the result is below r_den and fits WIDTH bits.
   assign w_diff   = w_trial[WIDTH-1:0] - r_den;

   assign w_q_fix   = (r_neg_n ^ r_neg_a) ? -r_num : r_num;
   assign w_rem_fix = r_neg_n ? -r_rem : r_rem;
   assign w_sat_res = f_sat(w_q_fix);

   assign bus.ready_o  = (r_state == S_IDLE);
   assign bus.valid_o  = (r_state == S_DONE);
   assign bus.x_sat_o  = r_x_sat;
   assign bus.q_full_o = r_q_full;
   assign bus.rem_o    = r_rem_out;
   assign bus.sat_o    = r_sat;
   assign bus.dz_o     = r_dz;

   always_ff @(posedge clk_i) begin
      if (!rst_ni)
         r_state <= S_IDLE;
      else
         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: if (bus.valid_i) w_state_nxt = w_a_zero ? S_DONE : S_CALC;
         S_CALC: if (r_cnt == '0) w_state_nxt = S_FIX;
         S_FIX:  w_state_nxt = S_DONE;
         S_DONE: if (bus.ready_i) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_cnt     <= '0;
         r_x_sat   <= '0;
         r_q_full  <= '0;
         r_rem_out <= '0;
         r_sat     <= 1'b0;
         r_dz      <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.valid_i) begin
                  r_num   <= w_n_mag;
                  r_den   <= w_a_mag;
                  r_rem   <= '0;
                  r_neg_n <= w_n[D-1];
                  r_neg_a <= bus.a_i[WIDTH-1];
                  r_cnt   <= CNT_W'(D-1);
                  if (w_a_zero) begin
                     r_x_sat   <= w_n[D-1] ? XMIN : XMAX;
                     r_q_full  <= '0;
                     r_rem_out <= '0;
                     r_sat     <= 1'b1;
                     r_dz      <= 1'b1;
                  end
               end
            end
            S_CALC: begin
               r_rem <= w_ge ? w_diff : w_trial[WIDTH-1:0];
               r_num <= {r_num[D-2:0], w_ge};
               r_cnt <= r_cnt - CNT_W'(1);
            end
            S_FIX: begin
               r_q_full  <= w_q_fix;
               r_rem_out <= w_rem_fix;
               r_x_sat   <= w_sat_res[WIDTH-1:0];
               r_sat     <= w_sat_res[WIDTH];
               r_dz      <= 1'b0;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_sub_div_unit.sv
// ---------------------------------------------------------------------------
// tb_sub_div_unit
// Directed vector table plus hand-written backpressure and reset sequences
// for sub_div_unit at default parameters (WIDTH=16, MAXN=16).
// ---------------------------------------------------------------------------
module tb_sub_div_unit;
   localparam int WIDTH = 16;
   localparam int MAXN  = 16;
   localparam int ACC_W = 36;
   localparam int D     = 37;
   localparam int NVEC  = 12;

   typedef struct {
      logic signed [ACC_W-1:0] y;
      logic signed [ACC_W-1:0] b;
      logic signed [WIDTH-1:0] a;
      logic signed [D-1:0]     q;
      logic signed [WIDTH-1:0] xs;
      logic signed [WIDTH-1:0] rem;
      logic                    sat;
      logic                    dz;
   } vec_t;

   logic clk_i = 1'b0;
   logic rst_ni;
   int   checks   = 0;
   int   failures = 0;
   vec_t vecs[NVEC];

   sub_div_unit_if #(.WIDTH(WIDTH), .MAXN(MAXN)) bus ();

   sub_div_unit #(.WIDTH(WIDTH), .MAXN(MAXN)) dut (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .bus    (bus)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string nm, input logic signed [63:0] act,
                      input logic signed [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
      end
   endtask

   task automatic set_vec(input int i, input longint y, input longint b,
                          input int a, input longint q, input int xs,
                          input int rem, input bit sat, input bit dz);
      vecs[i].y   = ACC_W'(y);
      vecs[i].b   = ACC_W'(b);
      vecs[i].a   = WIDTH'(a);
      vecs[i].q   = D'(q);
      vecs[i].xs  = WIDTH'(xs);
      vecs[i].rem = WIDTH'(rem);
      vecs[i].sat = sat;
      vecs[i].dz  = dz;
   endtask

   // Presents operands for one edge; returns the cycle index (accept edge is
   // cycle 0) in which valid_o is first high, or -1 if it never rises.
   task automatic run_op(input logic signed [ACC_W-1:0] y,
                         input logic signed [ACC_W-1:0] b,
                         input logic signed [WIDTH-1:0] a, output int lat);
      int c;
      bus.y_i     = y;
      bus.b_i     = b;
      bus.a_i     = a;
      bus.valid_i = 1'b1;
      @(posedge clk_i); #1;
      bus.valid_i = 1'b0;
      c = 0;
      while (!bus.valid_o && c < 100) begin
         @(posedge clk_i); #1;
         c++;
      end
      lat = bus.valid_o ? c + 1 : -1;
   endtask

   task automatic release_result();
      bus.ready_i = 1'b1;
      @(posedge clk_i); #1;
      bus.ready_i = 1'b0;
   endtask

   task automatic chk_zero_outputs(input string tag);
      chk({tag, "_ready"}, bus.ready_o, 1);
      chk({tag, "_valid"}, bus.valid_o, 0);
      chk({tag, "_x_sat"}, bus.x_sat_o, 0);
      chk({tag, "_q_full"}, bus.q_full_o, 0);
      chk({tag, "_rem"}, bus.rem_o, 0);
      chk({tag, "_sat"}, bus.sat_o, 0);
      chk({tag, "_dz"}, bus.dz_o, 0);
   endtask

   initial begin
      int lat;

      set_vec(0,  100,       30, 7,      10,       10,     0,  0, 0);
      set_vec(1,  -100,      3,  7,      -14,      -14,    -5, 0, 0);
      set_vec(2,  100,       0,  -7,     -14,      -14,    2,  0, 0);
      set_vec(3,  1000000,   0,  1,      1000000,  32767,  0,  1, 0);
      set_vec(4,  -(64'sd1 <<< 35), (64'sd1 <<< 35) - 1, -1,
                  (64'sd1 <<< 36) - 1, 32767, 0, 1, 0);
      set_vec(5,  1048576,   0,  -32768, -32,      -32,    0,  0, 0);
      set_vec(6,  5,         9,  0,      0,        -32768, 0,  1, 1);
      set_vec(7,  9,         5,  0,      0,        32767,  0,  1, 1);
      set_vec(8,  -1000000,  0,  3,      -333333,  -32768, -1, 1, 0);
      set_vec(9,  -65536,    0,  2,      -32768,   -32768, 0,  0, 0);
      set_vec(10, 65534,     0,  2,      32767,    32767,  0,  0, 0);
      set_vec(11, 65536,     0,  2,      32768,    32767,  0,  1, 0);

      rst_ni      = 1'b0;
      bus.valid_i = 1'b0;
      bus.ready_i = 1'b0;
      bus.y_i     = '0;
      bus.b_i     = '0;
      bus.a_i     = '0;
      repeat (3) @(posedge clk_i);
      #1;
      chk_zero_outputs("reset");
      rst_ni = 1'b1;
      @(posedge clk_i); #1;

      for (int i = 0; i < NVEC; i++) begin
         run_op(vecs[i].y, vecs[i].b, vecs[i].a, lat);
         chk($sformatf("v%0d_latency", i), lat, vecs[i].dz ? 1 : D + 2);
         chk($sformatf("v%0d_q_full", i), bus.q_full_o, vecs[i].q);
         chk($sformatf("v%0d_x_sat", i), bus.x_sat_o, vecs[i].xs);
         chk($sformatf("v%0d_rem", i), bus.rem_o, vecs[i].rem);
         chk($sformatf("v%0d_sat", i), bus.sat_o, vecs[i].sat);
         chk($sformatf("v%0d_dz", i), bus.dz_o, vecs[i].dz);
         release_result();
         chk($sformatf("v%0d_idle", i), bus.ready_o, 1);
      end

      // Backpressure: result held for 5 cycles while valid_i pulses.
      run_op(36'sd100, 36'sd30, 16'sd7, lat);
      chk("bp_latency", lat, D + 2);
      bus.y_i = 36'sd49;
      bus.b_i = 36'sd0;
      bus.a_i = 16'sd0;
      for (int i = 0; i < 5; i++) begin
         bus.valid_i = (i % 2 == 0);
         @(posedge clk_i); #1;
         chk($sformatf("bp%0d_valid", i), bus.valid_o, 1);
         chk($sformatf("bp%0d_ready", i), bus.ready_o, 0);
         chk($sformatf("bp%0d_q_full", i), bus.q_full_o, 10);
         chk($sformatf("bp%0d_x_sat", i), bus.x_sat_o, 10);
         chk($sformatf("bp%0d_dz", i), bus.dz_o, 0);
      end
      bus.valid_i = 1'b0;
      release_result();
      chk("bp_release_ready", bus.ready_o, 1);
      chk("bp_release_valid", bus.valid_o, 0);
      run_op(36'sd49, 36'sd0, 16'sd7, lat);
      chk("b2b_latency", lat, D + 2);
      chk("b2b_q_full", bus.q_full_o, 7);
      chk("b2b_x_sat", bus.x_sat_o, 7);
      release_result();

      // Reset in the middle of CALC discards the operation.
      bus.y_i     = 36'sd100;
      bus.b_i     = 36'sd30;
      bus.a_i     = 16'sd7;
      bus.valid_i = 1'b1;
      @(posedge clk_i); #1;
      bus.valid_i = 1'b0;
      repeat (9) begin
         @(posedge clk_i); #1;
      end
      chk("midcalc_busy", bus.ready_o, 0);
      chk("midcalc_q_prev", bus.q_full_o, 7);
      rst_ni = 1'b0;
      @(posedge clk_i); #1;
      chk_zero_outputs("midrst");
      rst_ni = 1'b1;
      @(posedge clk_i); #1;
      chk("postrst_valid", bus.valid_o, 0);
      run_op(36'sd49, 36'sd0, 16'sd7, lat);
      chk("postrst_latency", lat, D + 2);
      chk("postrst_q_full", bus.q_full_o, 7);
      chk("postrst_x_sat", bus.x_sat_o, 7);
      chk("postrst_rem", bus.rem_o, 0);
      release_result();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
